// File: rtl/ieee_adder_arbiter.sv
// Round-robin arbiter sharing one pipelined ieee_adder between two requesters, with tag-tracked result return.
// Build option: define ADDER_ARB_FIXED_PRIO_EN to make requester 0 always win contention.
`timescale 1ns/1ps

module ieee_adder_arbiter #(
  parameter int LATENCY = 3,
  parameter int CNT_W   = 16
) (
  input  logic               clock_in,
  input  logic               reset_in,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [63:0]        req_a,
  input  logic [63:0]        req_b,
  input  logic [1:0]         req_op,
  output logic [31:0]        adder_a,
  output logic [31:0]        adder_b,
  output logic               adder_op,
  input  logic [31:0]        adder_c,
  output logic [1:0]         resp_valid,
  output logic [31:0]        resp_data,
  output logic [2:0]         inflight,
  output logic [2*CNT_W-1:0] issue_cnt
);

  logic [1:0]       grant;
  logic             transfer;
  logic             sel;
  logic [LATENCY:0] tag_v;
  logic [LATENCY:0] tag_id;
  logic             resp_any;
  logic [CNT_W-1:0] cnt0;
  logic [CNT_W-1:0] cnt1;

`ifndef ADDER_ARB_FIXED_PRIO_EN
  logic last_grant;
`endif

  always_comb begin
    grant = 2'b00;
    if (!reset_in) begin
      unique case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
`ifdef ADDER_ARB_FIXED_PRIO_EN
        2'b11:   grant = 2'b01;
`else
        2'b11:   grant = last_grant ? 2'b01 : 2'b10;
`endif
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready = grant;
  assign transfer  = |grant;
  assign sel       = grant[1];

`ifndef ADDER_ARB_FIXED_PRIO_EN
  always_ff @(posedge clock_in) begin
    if (reset_in)      last_grant <= 1'b1;
    else if (transfer) last_grant <= sel;
  end
`endif

  // Operand registers present zeros on idle cycles so the adder sees a quiet bus.
  always_ff @(posedge clock_in) begin
    if (reset_in || !transfer) begin
      adder_a  <= '0;
      adder_b  <= '0;
      adder_op <= 1'b0;
    end else begin
      adder_a  <= sel ? req_a[63:32] : req_a[31:0];
      adder_b  <= sel ? req_b[63:32] : req_b[31:0];
      adder_op <= sel ? req_op[1] : req_op[0];
    end
  end

  // Stage 0 aligns with the operand registers; stage LATENCY aligns with adder_c.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      tag_v  <= '0;
      tag_id <= '0;
    end else begin
      tag_v  <= {tag_v[LATENCY-1:0], transfer};
      tag_id <= {tag_id[LATENCY-1:0], sel};
    end
  end

  assign resp_any   = tag_v[LATENCY];
  assign resp_valid = {resp_any & tag_id[LATENCY], resp_any & ~tag_id[LATENCY]};
  assign resp_data  = adder_c;

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      inflight <= '0;
    end else if (transfer && !resp_any) begin
      inflight <= inflight + 3'd1;
    end else if (!transfer && resp_any) begin
      inflight <= inflight - 3'd1;
    end
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (grant[0]) cnt0 <= cnt0 + 1'b1;
      if (grant[1]) cnt1 <= cnt1 + 1'b1;
    end
  end

  assign issue_cnt = {cnt1, cnt0};

endmodule

// File: doc/ieee_adder_arbiter.md
# ieee_adder_arbiter

Controller that shares one pipelined `ieee_adder` between two requesters. Each cycle it picks at most one pending operation by round-robin. It drives the adder's operand and op inputs from registers, and tracks every issued operation through the adder pipeline with a tag shift register. When `outputC` emerges, it routes the result back to the owning requester. It sits between client blocks and the adder instance, which is instantiated beside it at the next level up.

## Interface
- `LATENCY`, 3: adder pipeline depth in cycles, from `inputA/inputB/add_sub_bit` to `outputC`. Must be ≥1.
- `CNT_W`, 16: width of the per-requester issue counters.

- `clock_in` in 1: single clock; all state updates on the rising edge.
- `reset_in` in 1: synchronous, active-high reset.
- `req_valid` in 2: bit i means requester i has an operation pending.
- `req_ready` out 2: bit i means requester i's operation is accepted this cycle. It is combinational from `req_valid` and arbiter state.
- `req_a` in 64: operand A; bits [32i+31:32i] belong to requester i.
- `req_b` in 64: operand B, same packing as `req_a`.
- `req_op` in 2: bit i gives requester i's operation, 0 = add, 1 = subtract.
- `adder_a` out 32: drives adder `inputA`.
- `adder_b` out 32: drives adder `inputB`.
- `adder_op` out 1: drives adder `add_sub_bit`.
- `adder_c` in 32: from adder `outputC`.
- `resp_valid` out 2: one-cycle pulse; bit i means `resp_data` belongs to requester i.
- `resp_data` out 32: result. Equals `adder_c` passed through.
- `inflight` out 3: number of issued operations not yet returned.
- `issue_cnt` out 2*CNT_W: per-requester accepted-operation counters, packed like `req_a`.

## Operation
- Handshake: an operation transfers on a cycle where `req_valid[i] && req_ready[i]`.
  - At most one `req_ready` bit is high per cycle.
  - `req_ready[i]` is never high unless `req_valid[i]` is high.
  - There is no backpressure; the arbiter accepts every cycle when a request is pending.
- Arbitration, round-robin:
  - `last_grant` register, reset value 1, so requester 0 wins first after reset.
  - If both requests are valid, grant goes to the requester ≠ `last_grant`.
  - If only one is valid, that requester is granted.
  - `last_grant` updates only on a transfer.
- Issue stage (registered):
  - On a transfer from requester i, `adder_a/b/op` load requester i's operands and op.
  - Issue tag {v=1, id=i} loads into stage 0 of the tag pipe.
  - With no transfer, `adder_a/b/op` load 0 and the tag loads v=0.
- Tag pipe:
  - Stage 0 plus LATENCY further stages, shifting every cycle.
  - `resp_valid[id] = v` of the final stage; `resp_data = adder_c`.
  - `resp_data` is don't-care when no `resp_valid` bit is set.
- `inflight`:
  - Increments on a transfer and decrements on a `resp_valid` pulse.
  - A transfer and a response in the same cycle leave it unchanged.
  - Maximum is LATENCY+1; saturation is impossible by construction.
- `issue_cnt[i]` increments on each transfer from requester i and wraps modulo 2^CNT_W.
- Reset:
  - `req_ready` is combinationally 0 while `reset_in` is high.
  - `adder_a/b/op` = 0, all tag stages v=0, `resp_valid` = 0, `inflight` = 0, `issue_cnt` = 0, `last_grant` = 1.
  - Reset mid-operation discards all in-flight tags. Adder results still emerging after reset produce no `resp_valid`.

## Timing
- Transfer in cycle T → `adder_*` valid in cycle T+1 → `resp_valid` in cycle T+1+LATENCY (default T+4).
- Throughput: one operation per cycle total. Under continuous contention each requester gets every second cycle.
- Results return in issue order. Back-to-back results from different requesters appear in consecutive cycles.
- `resp_valid` is a single-cycle pulse per operation and is never repeated.

## Configuration
- `ADDER_ARB_FIXED_PRIO_EN`:
  - When defined, arbitration is fixed priority: requester 0 always wins contention and `last_grant` is unused.
  - When undefined, round-robin as above.
  - All other behaviour is identical in both builds.

## Test plan
- Reset, then `req_valid`=01, A=0x3FC00000 (1.5), B=0x3F000000 (0.5), op=0 → `req_ready`=01 in T; `resp_valid`=01 with `resp_data`=0x40000000 (2.0) in T+4; `inflight` returns to 0.
- Both valid every cycle for 8 cycles; req0 3.0−1.0 (0x40400000, 0x3F800000, op=1), req1 4.0+4.0 (0x40800000, 0x40800000) → grants alternate 0,1,0,1…; responses alternate 0x40000000 / 0x41000000; `issue_cnt` = 4/4.
- Same as previous with `ADDER_ARB_FIXED_PRIO_EN` defined → req1 never granted while req0 is held valid; `issue_cnt[1]` = 0.
- Issue 3 back-to-back ops from req1, assert `reset_in` one cycle later → no `resp_valid` pulses afterward; `inflight`=0 and `issue_cnt`=0 after reset.
- Simultaneous transfer and response → `inflight` unchanged; single-requester stream of 5 ops → `inflight` peaks at 4 (LATENCY+1).
- Preload `issue_cnt[0]` near wrap by issuing 65536 ops from req0 → `issue_cnt[0]` wraps to 0.
